// File: rtl/psum_accum.sv
// Read-modify-write accumulator in front of the psum memory, with a range drain port.
// Define PSUM_SAT_EN to make accumulation saturate to the signed range instead of wrapping.
module psum_accum #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_first,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_psum,
   output logic                  o_mem_rd_en,
   output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
   output logic                  o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wr_data,
   input  logic                  i_drain_start,
   input  logic [ADDR_WIDTH:0]   i_drain_len,
   output logic                  o_out_valid,
   output logic [DATA_WIDTH-1:0] o_out_data,
   input  logic                  i_out_ready,
   output logic                  o_busy,
   output logic                  o_drain_done
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ACC       = 3'd1,
      ST_FLUSH     = 3'd2,
      ST_DRAIN_RD  = 3'd3,
      ST_DRAIN_OUT = 3'd4
   } state_t;

   state_t                  state_r;
   logic                    s1_valid_r;
   logic                    s1_first_r;
   logic [ADDR_WIDTH-1:0]   s1_addr_r;
   logic [DATA_WIDTH-1:0]   s1_psum_r;
   logic                    fwd_valid_r;
   logic [ADDR_WIDTH-1:0]   fwd_addr_r;
   logic [DATA_WIDTH-1:0]   fwd_data_r;
   logic [ADDR_WIDTH:0]     cnt_r;
   logic [ADDR_WIDTH:0]     len_r;
   logic                    out_valid_r;
   logic                    fresh_r;
   logic [DATA_WIDTH-1:0]   hold_r;
   logic                    done_r;

   logic                    in_ready_s;
   logic                    accept_s;
   logic [DATA_WIDTH-1:0]   operand_s;
   logic [DATA_WIDTH-1:0]   wr_data_s;
   logic [ADDR_WIDTH:0]     cnt_inc_s;

   function automatic logic [DATA_WIDTH-1:0] acc_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] sum;
      sum = a + b;
`ifdef PSUM_SAT_EN
      if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
         sum = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
`endif
      return sum;
   endfunction

   // Input handshake, forwarding mux and memory port drive
   always_comb begin
      in_ready_s = ~i_rst & ((state_r == ST_IDLE) | (state_r == ST_ACC));
      accept_s   = i_valid & in_ready_s;
      cnt_inc_s  = cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
      // Memory is read-first, so a write one cycle back is not yet visible in the read data
      if (fwd_valid_r && (fwd_addr_r == s1_addr_r)) begin
         operand_s = fwd_data_r;
      end else begin
         operand_s = i_mem_rd_data;
      end
      if (s1_first_r) begin
         wr_data_s = s1_psum_r;
      end else begin
         wr_data_s = acc_add(operand_s, s1_psum_r);
      end
      if (state_r == ST_DRAIN_RD) begin
         o_mem_rd_en   = 1'b1;
         o_mem_rd_addr = cnt_r[ADDR_WIDTH-1:0];
      end else if (accept_s && !i_first) begin
         o_mem_rd_en   = 1'b1;
         o_mem_rd_addr = i_addr;
      end else begin
         o_mem_rd_en   = 1'b0;
         o_mem_rd_addr = {ADDR_WIDTH{1'b0}};
      end
      if (s1_valid_r) begin
         o_mem_wr_en   = 1'b1;
         o_mem_wr_addr = s1_addr_r;
         o_mem_wr_data = wr_data_s;
      end else begin
         o_mem_wr_en   = 1'b0;
         o_mem_wr_addr = {ADDR_WIDTH{1'b0}};
         o_mem_wr_data = {DATA_WIDTH{1'b0}};
      end
      o_out_data   = fresh_r ? i_mem_rd_data : hold_r;
      o_ready      = in_ready_s;
      o_out_valid  = out_valid_r;
      o_drain_done = done_r;
      o_busy       = (state_r != ST_IDLE) | s1_valid_r;
   end

   // S1 stage and the one-deep write history used for forwarding
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_r  <= 1'b0;
         s1_first_r  <= 1'b0;
         s1_addr_r   <= {ADDR_WIDTH{1'b0}};
         s1_psum_r   <= {DATA_WIDTH{1'b0}};
         fwd_valid_r <= 1'b0;
         fwd_addr_r  <= {ADDR_WIDTH{1'b0}};
         fwd_data_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_first_r <= i_first;
            s1_addr_r  <= i_addr;
            s1_psum_r  <= i_psum;
         end
         fwd_valid_r <= s1_valid_r;
         fwd_addr_r  <= s1_addr_r;
         fwd_data_r  <= wr_data_s;
      end
   end

   // Control FSM with registered drain outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {(ADDR_WIDTH+1){1'b0}};
         len_r       <= {(ADDR_WIDTH+1){1'b0}};
         out_valid_r <= 1'b0;
         fresh_r     <= 1'b0;
         hold_r      <= {DATA_WIDTH{1'b0}};
         done_r      <= 1'b0;
      end else begin
         done_r  <= 1'b0;
         fresh_r <= 1'b0;
         if (fresh_r) begin
            hold_r <= i_mem_rd_data;
         end
         case (state_r)
            ST_IDLE: begin
               if (i_drain_start) begin
                  len_r <= i_drain_len;
                  cnt_r <= {(ADDR_WIDTH+1){1'b0}};
               end
               if (accept_s) begin
                  state_r <= i_drain_start ? ST_FLUSH : ST_ACC;
               end else if (i_drain_start) begin
                  if (i_drain_len == {(ADDR_WIDTH+1){1'b0}}) begin
                     done_r <= 1'b1;
                  end else begin
                     state_r <= ST_DRAIN_RD;
                  end
               end
            end
            ST_ACC: begin
               if (i_drain_start) begin
                  len_r   <= i_drain_len;
                  cnt_r   <= {(ADDR_WIDTH+1){1'b0}};
                  state_r <= ST_FLUSH;
               end else if (!accept_s && !s1_valid_r) begin
                  state_r <= ST_IDLE;
               end
            end
            // Input is blocked here, so S1 retires during this single cycle
            ST_FLUSH: begin
               if (len_r == {(ADDR_WIDTH+1){1'b0}}) begin
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_DRAIN_RD;
               end
            end
            ST_DRAIN_RD: begin
               out_valid_r <= 1'b1;
               fresh_r     <= 1'b1;
               state_r     <= ST_DRAIN_OUT;
            end
            ST_DRAIN_OUT: begin
               if (i_out_ready) begin
                  out_valid_r <= 1'b0;
                  cnt_r       <= cnt_inc_s;
                  if (cnt_inc_s == len_r) begin
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     state_r <= ST_DRAIN_RD;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: read-first memory model, arithmetic reference memory,
// directed scenarios plus a randomized accumulate stream.
module tb_psum_accum;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_first;
   logic [7:0]  in_addr;
   logic [15:0] in_psum;
   logic        mem_rd_en;
   logic [7:0]  mem_rd_addr;
   logic [15:0] mem_rd_data;
   logic        mem_wr_en;
   logic [7:0]  mem_wr_addr;
   logic [15:0] mem_wr_data;
   logic        drain_start;
   logic [8:0]  drain_len;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic        busy;
   logic        drain_done;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem     [0:255];
   logic [15:0] ref_mem [0:255];

   psum_accum dut (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(in_ready), .i_first(in_first),
      .i_addr(in_addr), .i_psum(in_psum), .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr),
      .i_mem_rd_data(mem_rd_data), .o_mem_wr_en(mem_wr_en), .o_mem_wr_addr(mem_wr_addr),
      .o_mem_wr_data(mem_wr_data), .i_drain_start(drain_start), .i_drain_len(drain_len),
      .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
      .o_busy(busy), .o_drain_done(drain_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first synchronous memory: read data appears the cycle after rd_en
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
   end

   function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      return s[15:0];
   endfunction

   task automatic put_beat(input logic v, input logic f, input logic [7:0] a, input logic [15:0] p);
      in_valid = v; in_first = f; in_addr = a; in_psum = p;
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] p);
      @(negedge clk); put_beat(1'b1, 1'b1, a, p);
      @(negedge clk); put_beat(1'b0, 1'b0, 8'd0, 16'd0);
      ref_mem[a] = p;
   endtask

   task automatic do_drain(input int len, input int stall_idx, input int stall_n, input bit issue_start);
      int got, stall_left, dones, cyc;
      logic holding;
      logic [15:0] held;
      got = 0; stall_left = stall_n; dones = 0; cyc = 0; holding = 1'b0; held = 16'd0;
      if (issue_start) begin
         @(negedge clk); drain_start = 1'b1; drain_len = len[8:0];
      end
      while (got < len && cyc < 200) begin
         @(negedge clk); drain_start = 1'b0; cyc++;
         if (drain_done) dones++;
         out_ready = !(got == stall_idx && stall_left > 0);
         if (out_valid) begin
            total++;
            if (out_data !== ref_mem[got]) begin
               bad++; $display("FAIL drain_data idx=%0d got=%h exp=%h", got, out_data, ref_mem[got]);
            end
            if (holding) begin
               total++;
               if (out_data !== held) begin
                  bad++; $display("FAIL drain_stable got=%h exp=%h", out_data, held);
               end
            end
            if (out_ready) begin got++; holding = 1'b0; end
            else begin holding = 1'b1; held = out_data; stall_left--; end
         end
      end
      total++;
      if (got != len) begin bad++; $display("FAIL drain_timeout got=%0d exp=%0d", got, len); end
      repeat (3) begin
         @(negedge clk);
         if (drain_done) dones++;
      end
      total++;
      if (dones != 1) begin bad++; $display("FAIL drain_done_count got=%0d exp=1", dones); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle busy got=%b exp=0", busy); end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); #1;
      total++;
      if ({in_ready, mem_rd_en, mem_wr_en, out_valid, busy, drain_done} !== 6'd0 ||
          out_data !== 16'd0 || mem_wr_data !== 16'd0 || mem_rd_addr !== 8'd0) begin
         bad++; $display("FAIL reset_outputs got=%b exp=000000", {in_ready, mem_rd_en, mem_wr_en, out_valid, busy, drain_done});
      end
      @(negedge clk); rst = 1'b0; #1;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_release ready=%b busy=%b exp 1/0", in_ready, busy);
      end
   endtask

   task automatic test_overwrite();
      @(negedge clk); put_beat(1'b1, 1'b1, 8'd3, 16'd5); #1;
      total++;
      if (mem_rd_en !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL ovw_accept rd_en=%b ready=%b exp 0/1", mem_rd_en, in_ready);
      end
      @(negedge clk); put_beat(1'b0, 1'b0, 8'd0, 16'd0);
      total++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== 8'd3 || mem_wr_data !== 16'd5 || mem_rd_en !== 1'b0) begin
         bad++; $display("FAIL ovw_write en=%b addr=%h data=%h exp 1/03/0005", mem_wr_en, mem_wr_addr, mem_wr_data);
      end
      ref_mem[3] = 16'd5;
      @(negedge clk);
      total++;
      if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL ovw_single wr_en got=%b exp=0", mem_wr_en); end
   endtask

   task automatic test_accumulate();
      @(negedge clk); put_beat(1'b1, 1'b0, 8'd3, 16'hFFFE); #1;
      total++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 8'd3) begin
         bad++; $display("FAIL acc_read en=%b addr=%h exp 1/03", mem_rd_en, mem_rd_addr);
      end
      @(negedge clk); put_beat(1'b0, 1'b0, 8'd0, 16'd0);
      total++;
      if (mem_wr_en !== 1'b1 || mem_wr_addr !== 8'd3 || mem_wr_data !== 16'd3) begin
         bad++; $display("FAIL acc_write en=%b addr=%h data=%h exp 1/03/0003", mem_wr_en, mem_wr_addr, mem_wr_data);
      end
      ref_mem[3] = 16'd3;
   endtask

   task automatic test_hazard();
      logic [15:0] exp;
      preload(8'd7, 16'd10);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            exp = 16'(10 + k);
            total++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 8'd7 || mem_wr_data !== exp) begin
               bad++; $display("FAIL hazard_write%0d en=%b data=%h exp=%h", k, mem_wr_en, mem_wr_data, exp);
            end
         end
         if (k < 3) put_beat(1'b1, 1'b0, 8'd7, 16'd1);
         else put_beat(1'b0, 1'b0, 8'd0, 16'd0);
      end
      ref_mem[7] = 16'd13;
   endtask

   task automatic test_saturation();
      logic [15:0] exp;
`ifdef PSUM_SAT_EN
      exp = 16'h7FFF;
`else
      exp = 16'h8010;
`endif
      preload(8'd0, 16'h7FF0);
      @(negedge clk); put_beat(1'b1, 1'b0, 8'd0, 16'h0020);
      @(negedge clk); put_beat(1'b0, 1'b0, 8'd0, 16'd0);
      total++;
      if (mem_wr_en !== 1'b1 || mem_wr_data !== exp) begin
         bad++; $display("FAIL sat_write en=%b data=%h exp=%h", mem_wr_en, mem_wr_data, exp);
      end
      ref_mem[0] = exp;
   endtask

   task automatic test_drain_backpressure();
      preload(8'd0, 16'd1);
      preload(8'd1, 16'd2);
      preload(8'd2, 16'd3);
      do_drain(3, 1, 4, 1'b1);
   endtask

   task automatic test_drain_zero();
      @(negedge clk); drain_start = 1'b1; drain_len = 9'd0;
      @(negedge clk); drain_start = 1'b0;
      total++;
      if (drain_done !== 1'b1 || mem_rd_en !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL drain_zero done=%b rd_en=%b busy=%b exp 1/0/0", drain_done, mem_rd_en, busy);
      end
      @(negedge clk);
      total++;
      if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_zero_pulse got=%b exp=0", drain_done); end
   endtask

   task automatic test_flush();
      @(negedge clk); put_beat(1'b1, 1'b1, 8'd1, 16'd100); drain_start = 1'b1; drain_len = 9'd2; #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_accept ready got=%b exp=1", in_ready); end
      @(negedge clk); put_beat(1'b0, 1'b0, 8'd0, 16'd0); drain_start = 1'b0;
      total++;
      if (in_ready !== 1'b0 || mem_wr_en !== 1'b1 || mem_wr_data !== 16'd100 || busy !== 1'b1) begin
         bad++; $display("FAIL flush_state ready=%b wr_en=%b data=%h busy=%b exp 0/1/0064/1", in_ready, mem_wr_en, mem_wr_data, busy);
      end
      ref_mem[1] = 16'd100;
      do_drain(2, 0, 0, 1'b0);
   endtask

   task automatic test_random_stream();
      logic        pend, v, f;
      logic [7:0]  a, pa;
      logic [15:0] p, pd;
      for (int i = 0; i < 4; i++) preload(8'(i), 16'($urandom));
      @(negedge clk);
      pend = 1'b0; pa = 8'd0; pd = 16'd0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         total++;
         if (mem_wr_en !== pend || (pend && (mem_wr_addr !== pa || mem_wr_data !== pd))) begin
            bad++; $display("FAIL rand_write cyc=%0d en=%b addr=%h data=%h exp %b/%h/%h", i, mem_wr_en, mem_wr_addr, mem_wr_data, pend, pa, pd);
         end
         v = ($urandom_range(3, 0) != 0);
         f = ($urandom_range(5, 0) == 0);
         a = 8'($urandom_range(3, 0));
         p = 16'($urandom);
         put_beat(v, f, a, p);
         #1;
         total++;
         if (mem_rd_en !== (v & ~f) || (v && !f && mem_rd_addr !== a)) begin
            bad++; $display("FAIL rand_read cyc=%0d en=%b addr=%h exp %b/%h", i, mem_rd_en, mem_rd_addr, v & ~f, a);
         end
         pend = v;
         if (v) begin
            ref_mem[a] = f ? p : model_add(ref_mem[a], p);
            pa = a; pd = ref_mem[a];
         end
      end
      @(negedge clk); put_beat(1'b0, 1'b0, 8'd0, 16'd0);
      total++;
      if (mem_wr_en !== pend || (pend && mem_wr_data !== pd)) begin
         bad++; $display("FAIL rand_last en=%b data=%h exp %b/%h", mem_wr_en, mem_wr_data, pend, pd);
      end
      do_drain(4, 2, 3, 1'b1);
   endtask

   task automatic test_reset_mid_drain();
      bit seen;
      seen = 1'b0;
      @(negedge clk); drain_start = 1'b1; drain_len = 9'd3; out_ready = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk); drain_start = 1'b0;
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL mid_drain_timeout got=0 exp=1"); end
      #2 rst = 1'b1; #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL mid_drain_reset valid=%b busy=%b ready=%b exp 0/0/0", out_valid, busy, in_ready);
      end
      repeat (3) begin
         @(negedge clk);
         total++;
         if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            bad++; $display("FAIL mid_drain_quiet rd=%b wr=%b exp 0/0", mem_rd_en, mem_wr_en);
         end
      end
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk); put_beat(1'b1, 1'b0, 8'd2, 16'd5);
      @(negedge clk); put_beat(1'b0, 1'b0, 8'd0, 16'd0); #1;
      total++;
      if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL mid_acc_pending wr_en got=%b exp=1", mem_wr_en); end
      rst = 1'b1; #1;
      total++;
      if (mem_wr_en !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_acc_reset wr_en=%b busy=%b exp 0/0", mem_wr_en, busy);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_addr = 8'd0; in_psum = 16'd0;
      drain_start = 1'b0; drain_len = 9'd0; out_ready = 1'b1;
      test_reset();
      test_overwrite();
      test_accumulate();
      test_hazard();
      test_saturation();
      test_drain_backpressure();
      test_drain_zero();
      test_flush();
      test_random_stream();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
